// File: rtl/system_0_irq_ctrl_pkg.sv
// Shared constants for the system_0 interrupt controller: register map, FSM
// state encodings, VECTOR word layout and the maximum source count.
package system_0_irq_ctrl_pkg;

   localparam int MAX_SRC       = 16;
   localparam int VEC_VALID_BIT = 15;

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_ENABLE  = 3'd1;
   localparam logic [2:0] ADDR_EDGE    = 3'd2;
   localparam logic [2:0] ADDR_VECTOR  = 3'd3;
   localparam logic [2:0] ADDR_EOI     = 3'd4;
   localparam logic [2:0] ADDR_RAW     = 3'd5;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   function automatic logic [15:0] vector_word(input logic [3:0] id);
      vector_word                = '0;
      vector_word[VEC_VALID_BIT] = 1'b1;
      vector_word[3:0]           = id;
   endfunction

endpackage

// File: rtl/system_0_irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the active sources.
module system_0_irq_prio_enc #(
   parameter int NUM_SRC = 16
) (
   input  logic [NUM_SRC-1:0] req_i,
   output logic [3:0]         id_o,
   output logic               any_o
);

   // Scan downward so the lowest set index is the last assignment to stick.
   always_comb begin
      id_o = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) id_o = 4'(i);
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/system_0_irq_ctrl.sv
// Vectored interrupt controller with claim/EOI handshake, Avalon-MM slave.
// Define SYSTEM_0_IRQ_CTRL_SYNC_EN to add a 2-flop synchroniser on irq_src.
module system_0_irq_ctrl
   import system_0_irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               chipselect,
   input  logic [2:0]         address,
   input  logic               write_n,
   input  logic               read_n,
   input  logic [15:0]        writedata,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic [15:0]        readdata,
   output logic               irq
);

   logic [NUM_SRC-1:0] src_in, src_q, src_d, rise;
   logic [NUM_SRC-1:0] pending_q, pending_d, enable_q, edge_q, active, w1c;
   logic [MAX_SRC-1:0] active_w, claim_oh;
   logic [1:0]         state_q, state_d;
   logic [3:0]         vec_q, vec_d, win_id;
   logic               win_any, rd, wr, claim, eoi, irq_q;
   logic [15:0]        rdata, readdata_q;

`ifdef SYSTEM_0_IRQ_CTRL_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_src;
         sync2_q <= sync1_q;
      end
   end

   assign src_in = sync2_q;
`else
   assign src_in = irq_src;
`endif

   assign rd    = chipselect & ~read_n;
   assign wr    = chipselect & ~write_n;
   assign claim = rd & (address == ADDR_VECTOR) & (state_q == ST_ASSERT);
   assign eoi   = wr & (address == ADDR_EOI);
   assign w1c   = (wr && address == ADDR_PENDING) ? writedata[NUM_SRC-1:0] : '0;

   assign rise     = src_q & ~src_d;
   assign active   = pending_q & enable_q;
   assign active_w = MAX_SRC'(active);
   assign claim_oh = claim ? (MAX_SRC'(1) << vec_q) : '0;

   // Edge bits: a rise in the same cycle as a clear keeps the bit set.
   // Level bits simply follow the sampled line.
   assign pending_d = (edge_q & ((pending_q & ~w1c & ~claim_oh[NUM_SRC-1:0]) | rise))
                    | (~edge_q & src_q);

   system_0_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
      .req_i (active),
      .id_o  (win_id),
      .any_o (win_any)
   );

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               vec_d   = win_id;
               state_d = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (claim)                 state_d = ST_SERVICE;
            else if (!active_w[vec_q]) state_d = ST_IDLE;
         end
         ST_SERVICE: begin
            if (eoi) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rdata = '0;
      case (address)
         ADDR_PENDING: rdata = 16'(pending_q);
         ADDR_ENABLE:  rdata = 16'(enable_q);
         ADDR_EDGE:    rdata = 16'(edge_q);
         ADDR_VECTOR:  if (state_q == ST_ASSERT) rdata = vector_word(vec_q);
         ADDR_RAW:     rdata = 16'(src_q);
         default:      rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q      <= '0;
         src_d      <= '0;
         pending_q  <= '0;
         enable_q   <= '0;
         edge_q     <= '0;
         state_q    <= ST_IDLE;
         vec_q      <= '0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         src_q     <= src_in;
         src_d     <= src_q;
         pending_q <= pending_d;
         state_q   <= state_d;
         vec_q     <= vec_d;
         irq_q     <= (state_d == ST_ASSERT);
         if (wr && address == ADDR_ENABLE) enable_q <= writedata[NUM_SRC-1:0];
         if (wr && address == ADDR_EDGE)   edge_q   <= writedata[NUM_SRC-1:0];
         if (rd) readdata_q <= rdata;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_system_0_irq_ctrl.sv
// Directed bench for system_0_irq_ctrl: table-driven basic flow plus
// hand-written multi-cycle sequences for priority, level, drop and W1C races.
module tb_system_0_irq_ctrl;

   localparam int NS = 16;
`ifdef SYSTEM_0_IRQ_CTRL_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   localparam logic [1:0] OP_IDLE = 2'd0;
   localparam logic [1:0] OP_WR   = 2'd1;
   localparam logic [1:0] OP_RD   = 2'd2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          chipselect = 1'b0;
   logic [2:0]    address = '0;
   logic          write_n = 1'b1;
   logic          read_n = 1'b1;
   logic [15:0]   writedata = '0;
   logic [NS-1:0] irq_src = '0;
   logic [15:0]   readdata;
   logic          irq;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  addr;
      logic [15:0] wd;
      logic [15:0] src;
      logic        chk_rd;
      logic [15:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[$];

   system_0_irq_ctrl #(.NUM_SRC(NS)) dut (
      .clk        (clk),
      .reset      (reset),
      .chipselect (chipselect),
      .address    (address),
      .write_n    (write_n),
      .read_n     (read_n),
      .writedata  (writedata),
      .irq_src    (irq_src),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
      else passed++;
   endtask

   task automatic cyc(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d);
      chipselect = (op != OP_IDLE);
      write_n    = (op != OP_WR);
      read_n     = (op != OP_RD);
      address    = a;
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      read_n     = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(OP_IDLE, 3'd0, 16'h0);
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] a, input logic [15:0] exp);
      cyc(OP_RD, a, 16'h0);
      check(nm, readdata, exp);
   endtask

   // One-cycle pulse on the given sources; returns when irq should be high.
   task automatic pulse_to_irq(input logic [15:0] s);
      irq_src = s;
      idle(1);
      irq_src = '0;
      idle(1 + SL);
      idle(1);
   endtask

   function automatic void add(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d,
                               input logic [15:0] s, input logic cr, input logic [15:0] er,
                               input logic ei);
      vec_t v;
      v.op = op; v.addr = a; v.wd = d; v.src = s;
      v.chk_rd = cr; v.exp_rd = er; v.exp_irq = ei;
      tbl.push_back(v);
   endfunction

   initial begin
      // Basic edge flow on source 0, one row per clock.
      add(OP_RD,   3'd0, 16'h0,    16'h0, 1'b1, 16'h0000, 1'b0);
      add(OP_RD,   3'd1, 16'h0,    16'h0, 1'b1, 16'h0000, 1'b0);
      add(OP_RD,   3'd2, 16'h0,    16'h0, 1'b1, 16'h0000, 1'b0);
      add(OP_RD,   3'd5, 16'h0,    16'h0, 1'b1, 16'h0000, 1'b0);
      add(OP_WR,   3'd1, 16'h0001, 16'h0, 1'b0, 16'h0000, 1'b0);
      add(OP_WR,   3'd2, 16'h0001, 16'h0, 1'b0, 16'h0000, 1'b0);
      add(OP_IDLE, 3'd0, 16'h0,    16'h1, 1'b0, 16'h0000, 1'b0);
      for (int k = 0; k < SL; k++) add(OP_IDLE, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0000, 1'b0);
      add(OP_IDLE, 3'd0, 16'h0,    16'h0, 1'b0, 16'h0000, 1'b0);
      add(OP_IDLE, 3'd0, 16'h0,    16'h0, 1'b0, 16'h0000, 1'b1);
      add(OP_RD,   3'd3, 16'h0,    16'h0, 1'b1, 16'h8000, 1'b0);
      add(OP_RD,   3'd0, 16'h0,    16'h0, 1'b1, 16'h0000, 1'b0);
      add(OP_WR,   3'd4, 16'h1234, 16'h0, 1'b0, 16'h0000, 1'b0);
      add(OP_IDLE, 3'd0, 16'h0,    16'h0, 1'b0, 16'h0000, 1'b0);
      add(OP_RD,   3'd3, 16'h0,    16'h0, 1'b1, 16'h0000, 1'b0);
      add(OP_RD,   3'd6, 16'h0,    16'h0, 1'b1, 16'h0000, 1'b0);

      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset irq", 16'(irq), 16'h0);
      check("reset readdata", readdata, 16'h0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         irq_src = tbl[i].src;
         cyc(tbl[i].op, tbl[i].addr, tbl[i].wd);
         if (tbl[i].chk_rd) check($sformatf("row%0d readdata", i), readdata, tbl[i].exp_rd);
         check($sformatf("row%0d irq", i), 16'(irq), 16'(tbl[i].exp_irq));
      end

      // Sources 3 and 5 rise together: lowest wins, the other follows EOI.
      cyc(OP_WR, 3'd1, 16'h0028);
      cyc(OP_WR, 3'd2, 16'h0028);
      pulse_to_irq(16'h0028);
      check("s2 irq up", 16'(irq), 16'h1);
      rd_chk("s2 vector3", 3'd3, 16'h8003);
      check("s2 irq claimed", 16'(irq), 16'h0);
      rd_chk("s2 pending5", 3'd0, 16'h0020);
      cyc(OP_WR, 3'd4, 16'h0);
      check("s2 irq at eoi", 16'(irq), 16'h0);
      idle(1);
      check("s2 irq reassert", 16'(irq), 16'h1);
      rd_chk("s2 vector5", 3'd3, 16'h8005);
      cyc(OP_WR, 3'd4, 16'h0);
      idle(2);
      check("s2 irq quiet", 16'(irq), 16'h0);

      // Level source 2 held across EOI re-asserts; released it stays quiet.
      cyc(OP_WR, 3'd2, 16'h0000);
      cyc(OP_WR, 3'd1, 16'h0004);
      irq_src = 16'h0004;
      idle(3 + SL);
      check("s3 irq up", 16'(irq), 16'h1);
      rd_chk("s3 raw", 3'd5, 16'h0004);
      rd_chk("s3 vector", 3'd3, 16'h8002);
      cyc(OP_WR, 3'd0, 16'h0004);
      rd_chk("s3 w1c ignored", 3'd0, 16'h0004);
      cyc(OP_WR, 3'd4, 16'h0);
      check("s3 irq at eoi", 16'(irq), 16'h0);
      idle(1);
      check("s3 irq reassert", 16'(irq), 16'h1);
      rd_chk("s3 vector again", 3'd3, 16'h8002);
      irq_src = '0;
      idle(2 + SL);
      cyc(OP_WR, 3'd4, 16'h0);
      idle(2);
      check("s3 irq after release", 16'(irq), 16'h0);

      // Disabling the asserted source drops irq without a claim.
      cyc(OP_WR, 3'd2, 16'h0002);
      cyc(OP_WR, 3'd1, 16'h0002);
      pulse_to_irq(16'h0002);
      check("s4 irq up", 16'(irq), 16'h1);
      cyc(OP_WR, 3'd1, 16'h0000);
      check("s4 irq same edge", 16'(irq), 16'h1);
      idle(1);
      check("s4 irq dropped", 16'(irq), 16'h0);
      rd_chk("s4 vector empty", 3'd3, 16'h0000);
      rd_chk("s4 pending kept", 3'd0, 16'h0002);
      cyc(OP_WR, 3'd0, 16'h0002);
      rd_chk("s4 pending w1c", 3'd0, 16'h0000);

      // W1C racing a new rise on the same bit: the rise wins.
      cyc(OP_WR, 3'd2, 16'h0010);
      irq_src = 16'h0010;
      idle(1);
      irq_src = '0;
      idle(SL);
      cyc(OP_WR, 3'd0, 16'h0010);
      rd_chk("s5 set wins", 3'd0, 16'h0010);
      cyc(OP_WR, 3'd0, 16'h0010);
      rd_chk("s5 cleared", 3'd0, 16'h0000);

      // Reset while in service wipes everything.
      cyc(OP_WR, 3'd2, 16'h0001);
      cyc(OP_WR, 3'd1, 16'h0001);
      pulse_to_irq(16'h0001);
      rd_chk("s6 vector", 3'd3, 16'h8000);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check("s6 irq", 16'(irq), 16'h0);
      check("s6 readdata", readdata, 16'h0000);
      rd_chk("s6 enable", 3'd1, 16'h0000);
      rd_chk("s6 edge", 3'd2, 16'h0000);
      rd_chk("s6 pending", 3'd0, 16'h0000);
      rd_chk("s6 vector idle", 3'd3, 16'h0000);
      idle(2);
      check("s6 irq stays", 16'(irq), 16'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
